// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller (master) and memory (slave).
// Protocol: bus_req is held high with stable bus_we/bus_addr/bus_be/bus_wdata until the
// slave returns a one-cycle bus_ack (bus_rdata valid with it); at most one request is in flight.
interface dmem_access_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store sequencer: issues one bus request per op, stalls the pipe meanwhile,
// builds store lanes, extends load data and flags misalignment and ack timeouts.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_we,
  input  logic [1:0]  op_size,
  input  logic        op_sign,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        adel,
  output logic        ades,
  output logic        bus_err,
  output logic [1:0]  state_dbg,
  dmem_access_ctrl_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  logic [1:0]  state;
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_sign;
  logic [1:0]  lat_a;
  logic [7:0]  cnt;
  logic        drop;
  logic        req_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] shifted;
  logic [31:0] ext_data;
  logic        timeout_hit;

  assign accept = (state == IDLE) && op_valid && !flush;

  always_comb begin
    misaligned = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = op_wdata;
    case (op_size)
      2'b00: begin
        be_calc    = 4'b0001 << op_addr[1:0];
        wdata_calc = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = op_addr[0];
        be_calc    = op_addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{op_wdata[15:0]}};
      end
      default: misaligned = |op_addr[1:0];
    endcase
    if (!op_we) be_calc = 4'b1111;
  end

  // Lane select uses the offset latched at accept, not the live op_addr.
  assign shifted = bus.bus_rdata >> {lat_a, 3'b000};

  always_comb begin
    ext_data = shifted;
    case (lat_size)
      2'b00:   ext_data = {{24{lat_sign & shifted[7]}}, shifted[7:0]};
      2'b01:   ext_data = {{16{lat_sign & shifted[15]}}, shifted[15:0]};
      default: ext_data = shifted;
    endcase
  end

  assign timeout_hit = !bus.bus_ack && ((cnt + 8'd1) == TO_LIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lat_we   <= 1'b0;
      lat_size <= 2'b00;
      lat_sign <= 1'b0;
      lat_a    <= 2'b00;
      cnt      <= 8'd0;
      drop     <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= 32'd0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      ld_data  <= 32'd0;
      bus_err  <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt  <= 8'd0;
          drop <= 1'b0;
          if (accept) begin
            lat_we   <= op_we;
            lat_size <= op_size;
            lat_sign <= op_sign;
            lat_a    <= op_addr[1:0];
            if (misaligned) begin
              state <= ERR;
            end else begin
              addr_q  <= {op_addr[31:2], 2'b00};
              be_q    <= be_calc;
              wdata_q <= wdata_calc;
              req_q   <= 1'b1;
              state   <= REQ;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          if (flush) drop <= 1'b1;
          if (bus.bus_ack) begin
            req_q <= 1'b0;
            cnt   <= 8'd0;
            drop  <= 1'b0;
            // A flushed access still completes on the bus but leaves no trace.
            if (drop || flush) begin
              state <= IDLE;
            end else begin
              if (!lat_we) ld_data <= ext_data;
              state <= DONE;
            end
          end else if (timeout_hit) begin
            req_q   <= 1'b0;
            bus_err <= 1'b1;
            cnt     <= 8'd0;
            drop    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall     = op_valid && !flush && (state != DONE) && (state != ERR);
  assign done      = (state == DONE) && !flush;
  assign ld_valid  = done && !lat_we;
  assign adel      = (state == ERR) && !flush && !lat_we;
  assign ades      = (state == ERR) && !flush && lat_we;
  assign state_dbg = state;

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = lat_we;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed cases plus randomized ops against
// an arithmetic reference model; the bench also plays the memory side of the bus.
module tb_dmem_access_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_we, op_sign, flush;
  logic [1:0]  op_size;
  logic [31:0] op_addr, op_wdata;
  logic        stall, done, ld_valid, adel, ades, bus_err;
  logic [31:0] ld_data;
  logic [1:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_ld = 32'd0;
  logic [31:0] exp_q[$];

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_we(op_we), .op_size(op_size), .op_sign(op_sign),
    .op_addr(op_addr), .op_wdata(op_wdata), .flush(flush),
    .stall(stall), .done(done), .ld_valid(ld_valid), .ld_data(ld_data),
    .adel(adel), .ades(ades), .bus_err(bus_err), .state_dbg(state_dbg),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_misaligned(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd1) return (addr % 2) != 0;
    if (size >= 2'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] ref_be(input bit we, input logic [1:0] size, input logic [31:0] addr);
    int a;
    a = int'(addr % 4);
    if (!we) return 4'd15;
    if (size == 2'd0) return 4'(1 << a);
    if (size == 2'd1) return (a >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return (wd % 256) * 32'h01010101;
    if (size == 2'd1) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input bit sign,
                                           input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    v = rd / (32'd1 << (8 * (addr % 4)));
    if (size == 2'd0) begin
      v = v % 256;
      if (sign && v >= 128) v = v + 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      v = v % 65536;
      if (sign && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  // delay: REQ cycle carrying the ack (0 = never). flush_at: REQ cycle to flush,
  // or delay+1 to flush in the completion cycle (0 = no flush).
  task automatic run_op(input bit we, input logic [1:0] size, input bit sign,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int delay, input int flush_at);
    bit mis, timed_out, dropped, flush_done, pushed;
    mis = ref_misaligned(size, addr);
    timed_out = 1'b0;
    dropped = 1'b0;
    pushed = 1'b0;
    flush_done = (delay != 0) && (flush_at == delay + 1);
    @(negedge clk);
    op_valid = 1'b1; op_we = we; op_size = size; op_sign = sign;
    op_addr = addr; op_wdata = wd; flush = 1'b0;
    bus.bus_ack = 1'b0; bus.bus_rdata = rd;
    #1;
    check("accept_stall", stall, 1);
    check("accept_noreq", bus.bus_req, 0);
    if (mis) begin
      @(negedge clk); #1;
      check("adel", adel, 32'(!we));
      check("ades", ades, 32'(we));
      check("err_noreq", bus.bus_req, 0);
      check("err_stall", stall, 0);
      check("err_nodone", done, 0);
      op_valid = 1'b0;
      return;
    end
    if (!we) begin
      exp_q.push_back(ref_load(size, sign, addr, rd));
      pushed = 1'b1;
    end
    for (int r = 1; r <= TO; r++) begin
      @(negedge clk);
      bus.bus_ack = (r == delay);
      flush = (r == flush_at);
      if (r == flush_at) dropped = 1'b1;
      #1;
      check("req_high", bus.bus_req, 1);
      check("req_addr", bus.bus_addr, addr & 32'hFFFF_FFFC);
      check("req_be", bus.bus_be, ref_be(we, size, addr));
      check("req_we", bus.bus_we, 32'(we));
      if (we) check("req_wdata", bus.bus_wdata, ref_wdata(size, wd));
      check("req_stall", stall, 32'(r != flush_at));
      check("req_nodone", done, 0);
      if (r == delay) break;
      if (r == TO) timed_out = 1'b1;
    end
    @(negedge clk);
    bus.bus_ack = 1'b0;
    flush = flush_done;
    #1;
    if (pushed) begin
      if (!dropped && !timed_out) exp_ld = exp_q.pop_front();
      else void'(exp_q.pop_front());
    end
    if (timed_out) begin
      check("to_buserr", bus_err, 1);
      check("to_noreq", bus.bus_req, 0);
      check("to_nodone", done, 0);
    end else if (dropped) begin
      check("drop_nodone", done, 0);
      check("drop_noldv", ld_valid, 0);
      check("drop_noreq", bus.bus_req, 0);
    end else begin
      check("done", done, 32'(!flush_done));
      check("ld_valid", ld_valid, 32'(!flush_done && !we));
      check("done_stall", stall, 0);
      check("done_noerr", bus_err, 0);
    end
    check("ld_data", ld_data, exp_ld);
    op_valid = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    logic [31:0] addr;
    reset = 1'b0;
    op_valid = 1'b0; op_we = 1'b0; op_size = 2'd0; op_sign = 1'b0;
    op_addr = 32'd0; op_wdata = 32'd0; flush = 1'b0;
    bus.bus_ack = 1'b0; bus.bus_rdata = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req", bus.bus_req, 0);
    check("rst_done", done, 0);
    check("rst_ldv", ld_valid, 0);
    check("rst_ld", ld_data, 0);
    check("rst_exc", {29'd0, adel, ades, bus_err}, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b1;

    run_op(0, 2'd2, 0, 32'h100, 32'd0, 32'h8899AABB, 2, 0);
    check("tp_word", ld_data, 32'h8899AABB);
    run_op(0, 2'd0, 1, 32'h103, 32'd0, 32'h80112233, 1, 0);
    check("tp_sbyte", ld_data, 32'hFFFFFF80);
    run_op(0, 2'd0, 0, 32'h103, 32'd0, 32'h80112233, 3, 0);
    check("tp_ubyte", ld_data, 32'h00000080);
    run_op(0, 2'd1, 1, 32'h102, 32'd0, 32'h80112233, 2, 0);
    check("tp_shalf", ld_data, 32'hFFFF8011);
    run_op(1, 2'd0, 0, 32'h201, 32'h000000AB, 32'd0, 1, 0);
    check("tp_sb_wdata", bus.bus_wdata, 32'hABABABAB);
    check("tp_sb_be", bus.bus_be, 32'h2);
    run_op(1, 2'd1, 0, 32'h202, 32'h00001234, 32'd0, 3, 0);
    check("tp_sh_wdata", bus.bus_wdata, 32'h12341234);
    run_op(0, 2'd2, 0, 32'h102, 32'd0, 32'd0, 1, 0);
    run_op(1, 2'd1, 0, 32'h305, 32'h5555, 32'd0, 1, 0);
    run_op(0, 2'd2, 0, 32'h400, 32'd0, 32'h0, 0, 0);
    run_op(0, 2'd2, 0, 32'h404, 32'd0, 32'hCAFEF00D, TO, 0);
    check("tp_after_to", ld_data, 32'hCAFEF00D);
    run_op(0, 2'd2, 0, 32'h500, 32'd0, 32'hDEADBEEF, 3, 2);
    check("tp_flush_keep", ld_data, 32'hCAFEF00D);
    run_op(0, 2'd2, 0, 32'h504, 32'd0, 32'h11223344, 2, 3);
    run_op(0, 2'd3, 0, 32'h508, 32'd0, 32'h01020304, 1, 0);

    for (int i = 0; i < 80; i++) begin
      addr = $urandom;
      if ($urandom_range(0, 2) != 0) addr[1:0] = 2'd0;
      run_op(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
             addr, $urandom, $urandom,
             ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO),
             ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
    end

    @(negedge clk);
    op_valid = 1'b1; op_we = 1'b0; op_size = 2'd2; op_addr = 32'h600; flush = 1'b0;
    @(negedge clk); #1;
    check("mid_req_up", bus.bus_req, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_req", bus.bus_req, 0);
    check("async_ld", ld_data, 0);
    check("async_state", state_dbg, 0);
    check("async_stall", {31'd0, stall}, 1);
    op_valid = 1'b0;
    #1;
    check("async_stall_idle", stall, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_ld = 32'd0;
    run_op(0, 2'd1, 0, 32'h702, 32'd0, 32'hBEEF0000, 2, 0);
    check("post_rst_load", ld_data, 32'h0000BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
